// File: rtl/rv32_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_bus_arbiter_if
//  Purpose  : Bundles the instruction-fetch port, the data (mem stage) port
//             and the shared single-master bus of rv32_bus_arbiter.
//  Modports : slave  - the arbiter side (takes requests, drives the bus)
//             master - the requester / bus-model side (testbench, core)
//  Signals  : instr_*  fetch request/response channel
//             data_*   data request/response channel (with lock)
//             address_out, write_mask_out, write_value_out, read_out,
//             read_value_in  shared bus (read data one cycle after read_out)
//  Revision : 1.0 - initial release
// ============================================================================
interface rv32_bus_arbiter_if;
    logic        instr_valid_in;
    logic [31:0] instr_address_in;
    logic        instr_ready_out;
    logic        instr_read_valid_out;
    logic [31:0] instr_read_value_out;

    logic        data_valid_in;
    logic [31:0] data_address_in;
    logic [3:0]  data_write_mask_in;
    logic [31:0] data_write_value_in;
    logic        data_lock_in;
    logic        data_ready_out;
    logic        data_read_valid_out;
    logic [31:0] data_read_value_out;

    logic [31:0] address_out;
    logic [3:0]  write_mask_out;
    logic [31:0] write_value_out;
    logic        read_out;
    logic [31:0] read_value_in;

    modport slave (
        input  instr_valid_in, instr_address_in,
        output instr_ready_out, instr_read_valid_out, instr_read_value_out,
        input  data_valid_in, data_address_in, data_write_mask_in,
        input  data_write_value_in, data_lock_in,
        output data_ready_out, data_read_valid_out, data_read_value_out,
        output address_out, write_mask_out, write_value_out, read_out,
        input  read_value_in
    );

    modport master (
        output instr_valid_in, instr_address_in,
        input  instr_ready_out, instr_read_valid_out, instr_read_value_out,
        output data_valid_in, data_address_in, data_write_mask_in,
        output data_write_value_in, data_lock_in,
        input  data_ready_out, data_read_valid_out, data_read_value_out,
        input  address_out, write_mask_out, write_value_out, read_out,
        output read_value_in
    );
endinterface
`default_nettype wire

// File: rtl/rv32_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_bus_arbiter
//  Purpose  : Two-requester (fetch, data) arbiter onto one shared bus with a
//             one-cycle read response path and a data-side bus lock for
//             read-modify-write sequences.
//  Ports    : clk   - clock, all state on the rising edge
//             reset - asynchronous, active-high reset
//             bus   - rv32_bus_arbiter_if.slave (request, response and
//                     shared bus signals)
//  Options  : RV32_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests
//             alternate via a round-robin pointer; otherwise data has fixed
//             priority over fetch.
//  Revision : 1.0 - initial release
// ============================================================================
module rv32_bus_arbiter (
    input  wire logic           clk,
    input  wire logic           reset,
    rv32_bus_arbiter_if.slave   bus
);

    localparam logic [0:0] c_UNLOCKED  = 1'b0;
    localparam logic [0:0] c_LOCKED    = 1'b1;

    localparam logic [1:0] c_OWN_NONE  = 2'd0;
    localparam logic [1:0] c_OWN_INSTR = 2'd1;
    localparam logic [1:0] c_OWN_DATA  = 2'd2;

    logic [0:0] r_lock_state;
    logic [0:0] w_lock_next;
    logic [1:0] r_owner;       // who receives read_value_in this cycle
    logic [1:0] w_owner_next;
    logic       w_grant_instr;
    logic       w_grant_data;
    logic       w_data_is_read;

    assign w_data_is_read = (bus.data_write_mask_in == 4'b0000);

`ifdef RV32_ARB_ROUND_ROBIN_EN
    logic r_favour_data;       // 1: data wins a tie, 0: fetch wins a tie
    logic w_favour_data_next;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_state <= c_UNLOCKED;
            r_owner      <= c_OWN_NONE;
        end else begin
            r_lock_state <= w_lock_next;
            r_owner      <= w_owner_next;
        end
    end

`ifdef RV32_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_favour_data <= 1'b1;
        end else begin
            r_favour_data <= w_favour_data_next;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Grant decision. A grant is the ready_out, so grant == transfer.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_instr = 1'b0;
        w_grant_data  = 1'b0;
        if (r_lock_state == c_LOCKED) begin
            // Bus is reserved for the data side; fetch waits.
            w_grant_data = bus.data_valid_in;
        end else if (bus.data_valid_in && bus.instr_valid_in) begin
`ifdef RV32_ARB_ROUND_ROBIN_EN
            w_grant_data  = r_favour_data;
            w_grant_instr = ~r_favour_data;
`else
            w_grant_data  = 1'b1;
`endif
        end else begin
            w_grant_data  = bus.data_valid_in;
            w_grant_instr = bus.instr_valid_in;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_lock_next  = r_lock_state;
        w_owner_next = c_OWN_NONE;
        // Lock is only sampled on an actual data transfer.
        if (w_grant_data) begin
            w_lock_next = bus.data_lock_in ? c_LOCKED : c_UNLOCKED;
        end
        // Owner is rewritten every cycle, allowing back-to-back reads.
        if (w_grant_data && w_data_is_read) begin
            w_owner_next = c_OWN_DATA;
        end else if (w_grant_instr) begin
            w_owner_next = c_OWN_INSTR;
        end
    end

`ifdef RV32_ARB_ROUND_ROBIN_EN
    always_comb begin
        w_favour_data_next = r_favour_data;
        if (w_grant_data) begin
            w_favour_data_next = 1'b0;
        end else if (w_grant_instr) begin
            w_favour_data_next = 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs: handshake, shared bus, and read responses
    // ------------------------------------------------------------------
    always_comb begin
        bus.instr_ready_out      = w_grant_instr;
        bus.data_ready_out       = w_grant_data;
        bus.address_out          = 32'd0;
        bus.write_mask_out       = 4'b0000;
        bus.write_value_out      = 32'd0;
        bus.read_out             = 1'b0;
        bus.instr_read_valid_out = 1'b0;
        bus.instr_read_value_out = 32'd0;
        bus.data_read_valid_out  = 1'b0;
        bus.data_read_value_out  = 32'd0;

        if (w_grant_data) begin
            bus.address_out     = bus.data_address_in;
            bus.write_mask_out  = bus.data_write_mask_in;
            bus.write_value_out = bus.data_write_value_in;
            bus.read_out        = w_data_is_read;
        end else if (w_grant_instr) begin
            bus.address_out     = bus.instr_address_in;
            bus.read_out        = 1'b1;
        end

        // Owner is cleared asynchronously by reset, so an in-flight read
        // response disappears the moment reset asserts.
        if (r_owner == c_OWN_INSTR) begin
            bus.instr_read_valid_out = 1'b1;
            bus.instr_read_value_out = bus.read_value_in;
        end else if (r_owner == c_OWN_DATA) begin
            bus.data_read_valid_out  = 1'b1;
            bus.data_read_value_out  = bus.read_value_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32_bus_arbiter
//  Purpose  : Directed self-checking bench for rv32_bus_arbiter. Expected
//             values are hand-computed; the tie-break expectations follow
//             RV32_ARB_ROUND_ROBIN_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_bus_arbiter;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    rv32_bus_arbiter_if bus ();

    rv32_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.instr_valid_in      = 1'b0;
        bus.instr_address_in    = 32'd0;
        bus.data_valid_in       = 1'b0;
        bus.data_address_in     = 32'd0;
        bus.data_write_mask_in  = 4'b0000;
        bus.data_write_value_in = 32'd0;
        bus.data_lock_in        = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle_inputs();
        bus.read_value_in = 32'd0;
        reset = 1'b1;

        // ---------------- reset state ----------------
        #12;
        chk("rst_instr_rvalid", {31'd0, bus.instr_read_valid_out}, 32'd0);
        chk("rst_data_rvalid",  {31'd0, bus.data_read_valid_out},  32'd0);
        chk("rst_read_out",     {31'd0, bus.read_out},             32'd0);
        chk("rst_address",      bus.address_out,                   32'd0);
        reset = 1'b0;
        tick();

        // ---------------- single fetch read ----------------
        bus.instr_valid_in   = 1'b1;
        bus.instr_address_in = 32'h0000_0100;
        #1;
        chk("f_instr_ready", {31'd0, bus.instr_ready_out}, 32'd1);
        chk("f_data_ready",  {31'd0, bus.data_ready_out},  32'd0);
        chk("f_address",     bus.address_out,              32'h100);
        chk("f_read_out",    {31'd0, bus.read_out},        32'd1);
        chk("f_wmask",       {28'd0, bus.write_mask_out},  32'd0);
        tick();
        idle_inputs();
        bus.read_value_in = 32'hDEAD_BEEF;
        #1;
        chk("f_rvalid",       {31'd0, bus.instr_read_valid_out}, 32'd1);
        chk("f_rvalue",       bus.instr_read_value_out,          32'hDEAD_BEEF);
        chk("f_data_rvalid",  {31'd0, bus.data_read_valid_out},  32'd0);
        chk("f_data_rvalue",  bus.data_read_value_out,           32'd0);
        chk("idle_address",   bus.address_out,                   32'd0);
        chk("idle_read_out",  {31'd0, bus.read_out},             32'd0);
        tick();
        chk("f_rvalid_gone",  {31'd0, bus.instr_read_valid_out}, 32'd0);
        chk("f_rvalue_zero",  bus.instr_read_value_out,          32'd0);

        // ---------------- simultaneous requests, 4 cycles ----------------
        bus.instr_valid_in      = 1'b1;
        bus.instr_address_in    = 32'h0000_0100;
        bus.data_valid_in       = 1'b1;
        bus.data_address_in     = 32'h0000_0200;
        bus.data_write_mask_in  = 4'b1111;
        bus.data_write_value_in = 32'hA5A5_5A5A;
        for (int i = 0; i < 4; i++) begin
            logic exp_data;
`ifdef RV32_ARB_ROUND_ROBIN_EN
            exp_data = (i % 2 == 0);
`else
            exp_data = 1'b1;
`endif
            #1;
            chk($sformatf("both_data_ready_%0d", i),  {31'd0, bus.data_ready_out},  {31'd0, exp_data});
            chk($sformatf("both_instr_ready_%0d", i), {31'd0, bus.instr_ready_out}, {31'd0, ~exp_data});
            chk($sformatf("both_address_%0d", i),     bus.address_out,
                exp_data ? 32'h200 : 32'h100);
            chk($sformatf("both_wmask_%0d", i),       {28'd0, bus.write_mask_out},
                exp_data ? 32'hF : 32'h0);
            chk($sformatf("both_wvalue_%0d", i),      bus.write_value_out,
                exp_data ? 32'hA5A5_5A5A : 32'h0);
            chk($sformatf("both_read_out_%0d", i),    {31'd0, bus.read_out}, {31'd0, ~exp_data});
            tick();
            chk($sformatf("both_no_data_rvalid_%0d", i), {31'd0, bus.data_read_valid_out}, 32'd0);
        end
        idle_inputs();
        tick();

        // ---------------- lock sequence ----------------
        bus.data_valid_in   = 1'b1;
        bus.data_address_in = 32'h0000_0300;
        bus.data_lock_in    = 1'b1;
        #1;
        chk("lk_data_ready", {31'd0, bus.data_ready_out}, 32'd1);
        chk("lk_read_out",   {31'd0, bus.read_out},       32'd1);
        chk("lk_address",    bus.address_out,             32'h300);
        tick();
        idle_inputs();
        bus.data_lock_in     = 1'b1;   // must be ignored while data is idle
        bus.instr_valid_in   = 1'b1;
        bus.instr_address_in = 32'h0000_0100;
        bus.read_value_in    = 32'h1234_5678;
        #1;
        chk("lk_data_rvalid", {31'd0, bus.data_read_valid_out}, 32'd1);
        chk("lk_data_rvalue", bus.data_read_value_out,          32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lk_instr_blocked_%0d", i), {31'd0, bus.instr_ready_out}, 32'd0);
            chk($sformatf("lk_bus_idle_%0d", i),      bus.address_out,              32'd0);
            chk($sformatf("lk_no_read_%0d", i),       {31'd0, bus.read_out},        32'd0);
            tick();
            #1;
        end
        bus.data_valid_in       = 1'b1;
        bus.data_address_in     = 32'h0000_0300;
        bus.data_write_mask_in  = 4'b1111;
        bus.data_write_value_in = 32'h0BAD_F00D;
        bus.data_lock_in        = 1'b0;
        #1;
        chk("ul_data_ready",  {31'd0, bus.data_ready_out},  32'd1);
        chk("ul_instr_ready", {31'd0, bus.instr_ready_out}, 32'd0);
        chk("ul_wmask",       {28'd0, bus.write_mask_out},  32'hF);
        chk("ul_wvalue",      bus.write_value_out,          32'h0BAD_F00D);
        tick();
        bus.data_valid_in      = 1'b0;
        bus.data_write_mask_in = 4'b0000;
        #1;
        chk("ul_instr_granted",  {31'd0, bus.instr_ready_out},     32'd1);
        chk("ul_write_no_rvalid", {31'd0, bus.data_read_valid_out}, 32'd0);
        tick();
        idle_inputs();
        tick();

        // ---------------- alternating back-to-back reads ----------------
        bus.instr_valid_in   = 1'b1;
        bus.instr_address_in = 32'h0000_0010;
        tick();
        bus.instr_valid_in  = 1'b0;
        bus.data_valid_in   = 1'b1;
        bus.data_address_in = 32'h0000_0020;
        bus.read_value_in   = 32'h1111_1111;
        #1;
        chk("alt1_instr_rvalid", {31'd0, bus.instr_read_valid_out}, 32'd1);
        chk("alt1_instr_rvalue", bus.instr_read_value_out,          32'h1111_1111);
        chk("alt1_data_rvalid",  {31'd0, bus.data_read_valid_out},  32'd0);
        chk("alt1_data_ready",   {31'd0, bus.data_ready_out},       32'd1);
        tick();
        bus.data_valid_in    = 1'b0;
        bus.instr_valid_in   = 1'b1;
        bus.instr_address_in = 32'h0000_0030;
        bus.read_value_in    = 32'h2222_2222;
        #1;
        chk("alt2_data_rvalid",  {31'd0, bus.data_read_valid_out},  32'd1);
        chk("alt2_data_rvalue",  bus.data_read_value_out,           32'h2222_2222);
        chk("alt2_instr_rvalid", {31'd0, bus.instr_read_valid_out}, 32'd0);
        chk("alt2_instr_rvalue", bus.instr_read_value_out,          32'd0);
        tick();
        idle_inputs();
        bus.read_value_in = 32'h3333_3333;
        #1;
        chk("alt3_instr_rvalid", {31'd0, bus.instr_read_valid_out}, 32'd1);
        chk("alt3_instr_rvalue", bus.instr_read_value_out,          32'h3333_3333);
        chk("alt3_data_rvalid",  {31'd0, bus.data_read_valid_out},  32'd0);
        tick();

        // ---------------- reset mid-cycle with a read in flight ----------------
        bus.data_valid_in   = 1'b1;
        bus.data_address_in = 32'h0000_0040;
        bus.data_lock_in    = 1'b1;
        tick();
        idle_inputs();
        bus.read_value_in = 32'h4444_4444;
        #1;
        chk("rr_data_rvalid_before", {31'd0, bus.data_read_valid_out}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rr_data_rvalid_dropped", {31'd0, bus.data_read_valid_out}, 32'd0);
        chk("rr_data_rvalue_zero",    bus.data_read_value_out,          32'd0);
        #1;
        reset = 1'b0;
        bus.instr_valid_in   = 1'b1;
        bus.instr_address_in = 32'h0000_0500;
        #1;
        chk("rr_unlocked_instr_ready", {31'd0, bus.instr_ready_out}, 32'd1);
        chk("rr_unlocked_address",     bus.address_out,              32'h500);
        tick();
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/rv32_bus_arbiter.md
RV32_BUS_ARBITER -- requirements
Module: rv32_bus_arbiter

Interface
REQ-001 The module SHALL provide the following ports, one per line as name, direction, width, meaning.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid_in  in  1  fetch requests a read.
- instr_address_in  in  32  fetch read address.
- instr_ready_out  out  1  fetch request accepted this cycle.
- instr_read_valid_out  out  1  fetch read data valid.
- instr_read_value_out  out  32  fetch read data.
- data_valid_in  in  1  mem stage requests a read or write.
- data_address_in  in  32  mem stage address.
- data_write_mask_in  in  4  byte write enables; 4'b0000 means read.
- data_write_value_in  in  32  write data.
- data_lock_in  in  1  hold the bus for data after the current transfer (read-modify-write).
- data_ready_out  out  1  data request accepted this cycle.
- data_read_valid_out  out  1  data read data valid.
- data_read_value_out  out  32  data read data.
- address_out  out  32  shared bus address.
- write_mask_out  out  4  shared bus byte write enables.
- write_value_out  out  32  shared bus write data.
- read_out  out  1  shared bus read strobe.
- read_value_in  in  32  shared bus read data, valid one cycle after read_out.

Function
REQ-002 Transfer SHALL occur on a requester when its valid_in and ready_out are both high at a rising clk edge; at most one transfer per cycle.
REQ-003 ready_out SHALL be combinational from the valid inputs and arbiter state; at most one ready_out high per cycle, never ready without valid.
REQ-004 The bus outputs SHALL combinationally reflect the granted requester: address_out = granted address; write_mask_out = data_write_mask_in if data is granted, else 0; write_value_out = data_write_value_in if data is granted, else 0; read_out = 1 for a granted read (instr always; data when mask = 0).
REQ-005 With no grant, address_out, write_mask_out, write_value_out and read_out SHALL be 0.
REQ-006 Read latency SHALL be exactly one cycle: the cycle after a read transfer, the owner's read_valid_out = 1 and read_value_out = read_value_in; the other requester's read_valid_out = 0.
REQ-007 read_value_out SHALL be 0 whenever the corresponding read_valid_out is 0.
REQ-008 A response owner register (none/instr/data) SHALL be written each cycle from that cycle's transfer, so back-to-back reads from either requester are allowed with no bubble.
REQ-009 Writes SHALL produce no read_valid_out pulse.
REQ-010 Lock FSM states: UNLOCKED, LOCKED. The FSM SHALL go UNLOCKED->LOCKED on a data transfer with data_lock_in = 1.
REQ-011 The FSM SHALL go LOCKED->UNLOCKED on a data transfer with data_lock_in = 0.
REQ-012 In LOCKED, instr_ready_out SHALL be 0 and data_ready_out SHALL equal data_valid_in.
REQ-013 In LOCKED with data_valid_in = 0, the FSM SHALL stay LOCKED and the bus SHALL be idle.
REQ-014 data_lock_in SHALL be ignored when data_valid_in = 0.
REQ-015 Arbitration in UNLOCKED with one valid requester SHALL grant that requester.
REQ-016 Arbitration in UNLOCKED with both requesters valid SHALL follow REQ-020/REQ-021.

Reset
REQ-017 While reset = 1, the lock FSM SHALL be UNLOCKED, the response owner SHALL be none, and the round-robin pointer SHALL point to data.
REQ-018 Assertion of reset SHALL take effect immediately, without waiting for a clk edge.
REQ-019 A read in flight when reset asserts SHALL be dropped, and both read_valid_out SHALL be 0 from reset assertion until a new read transfer completes.

Configuration
REQ-020 With RV32_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester the pointer favours; after every granted transfer the pointer SHALL favour the other requester.
REQ-021 Without RV32_ARB_ROUND_ROBIN_EN, data SHALL have fixed priority over instr; the pointer register SHALL be absent.

Verification
REQ-022 Instr read 0x100 alone -> same cycle instr_ready_out = 1, address_out = 0x100, read_out = 1; next cycle instr_read_valid_out = 1 with value = read_value_in.
REQ-023 Both valid for 4 cycles (data write mask 4'b1111 to 0x200, instr read 0x100) -> fixed: data granted all 4 cycles; RR: grants data, instr, data, instr.
REQ-024 Data read 0x300 with lock = 1, then instr valid for 3 cycles with data idle -> instr_ready_out = 0 for those cycles; data write 0x300 with lock = 0 -> next cycle instr granted.
REQ-025 Alternating instr/data reads on consecutive cycles -> each read_valid_out pulses only for its own read, one cycle later, with no bubbles.
REQ-026 Reset asserted mid-cycle after a data read transfer -> data_read_valid_out = 0 immediately, and FSM UNLOCKED after release.
